// File: rtl/analog_dir_mapper_if.sv
// Stick/d-pad bundle between hps_io joystick outputs and analog_dir_mapper.
// master drives samples and d-pad state; slave returns the direction nibbles.
interface analog_dir_mapper_if #(
    parameter int NUM_CH = 4,
    parameter int AXIS_W = 8
);
    logic                                 sample_en;
    logic [NUM_CH-1:0][2*AXIS_W-1:0]      analog_in;
    logic [NUM_CH-1:0][3:0]               dig_in;
    logic [NUM_CH-1:0]                    four_way;
    logic [NUM_CH-1:0][3:0]               dir_out;
    logic [NUM_CH-1:0]                    active;

    modport master (output sample_en, analog_in, dig_in, four_way,
                    input  dir_out, active);
    modport slave  (input  sample_en, analog_in, dig_in, four_way,
                    output dir_out, active);
endinterface

// File: rtl/analog_dir_mapper.sv
// Analog stick -> debounced {up,down,left,right} nibbles for NUM_CH channels.
// Optional ANALOG_DIR_AUTOCAL_EN: first sample after reset captures per-axis centre offsets.
module analog_dir_axis #(
    parameter int AXIS_W    = 8,
    parameter int DEAD_ZONE = 32,
    parameter int HYST      = 8,
    parameter int DEBOUNCE  = 2
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     eval,
    input  logic signed [AXIS_W-1:0] v,
    output logic                     pos,
    output logic                     neg,
    output logic                     act_nxt
);
    localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]   DB   = CW'(DEBOUNCE);
    localparam logic [AXIS_W:0] DZ   = (AXIS_W+1)'(DEAD_ZONE);
    localparam logic [AXIS_W:0] EXIT = (AXIS_W+1)'(DEAD_ZONE - HYST);

    typedef enum logic [1:0] {CENTER, POS, NEG} axis_st_e;

    axis_st_e        st_q, st_d, last_q, last_d, cand;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_eff;
    logic [AXIS_W:0] vx, mag;
    logic            far;

    // one extra bit so the most-negative input yields 2^(AXIS_W-1)
    assign vx  = {v[AXIS_W-1], v};
    assign mag = v[AXIS_W-1] ? (~vx + 1'b1) : vx;
    assign far = (mag >= DZ);

    always_comb begin
        cand = st_q;
        case (st_q)
            CENTER: if (far) cand = v[AXIS_W-1] ? NEG : POS;
            POS: begin
                if (far && v[AXIS_W-1])  cand = NEG;
                else if (mag < EXIT)     cand = CENTER;
            end
            NEG: begin
                if (far && !v[AXIS_W-1]) cand = POS;
                else if (mag < EXIT)     cand = CENTER;
            end
            default: cand = CENTER;
        endcase
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cnt_eff = (cand == last_q) ? cnt_q : '0;
        if (eval) begin
            last_d = cand;
            if (cand == st_q) begin
                cnt_d = '0;
            end else if (cnt_eff == DB) begin
                st_d  = cand;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_eff + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            st_q   <= CENTER;
            last_q <= CENTER;
            cnt_q  <= '0;
        end else begin
            st_q   <= st_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pos     = (st_q == POS);
    assign neg     = (st_q == NEG);
    assign act_nxt = (st_d != CENTER);
endmodule

module analog_dir_chan #(
    parameter int AXIS_W    = 8,
    parameter int DEAD_ZONE = 32,
    parameter int HYST      = 8,
    parameter int DEBOUNCE  = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  eval,
    input  logic                  cal,
    input  logic [2*AXIS_W-1:0]   raw,
    input  logic [3:0]            dig,
    input  logic                  four_way,
    output logic [3:0]            dir
);
    logic signed [AXIS_W-1:0] vx, vy;
    logic x_pos, x_neg, x_nxt, y_pos, y_neg, y_nxt, x_act, y_act;
    logic prim_y_q;
    logic [3:0] analog;

`ifdef ANALOG_DIR_AUTOCAL_EN
    localparam logic [AXIS_W:0] DZ = (AXIS_W+1)'(DEAD_ZONE);
    logic signed [AXIS_W-1:0] off_x_q, off_y_q;

    function automatic logic signed [AXIS_W-1:0] sat_sub(input logic [AXIS_W-1:0] a,
                                                         input logic [AXIS_W-1:0] b);
        logic [AXIS_W:0] d;
        d = {a[AXIS_W-1], a} - {b[AXIS_W-1], b};
        if (d[AXIS_W] != d[AXIS_W-1])
            sat_sub = d[AXIS_W] ? {1'b1, {(AXIS_W-1){1'b0}}} : {1'b0, {(AXIS_W-1){1'b1}}};
        else
            sat_sub = d[AXIS_W-1:0];
    endfunction

    function automatic logic in_zone(input logic [AXIS_W-1:0] a);
        logic [AXIS_W:0] ext, m;
        ext = {a[AXIS_W-1], a};
        m   = a[AXIS_W-1] ? (~ext + 1'b1) : ext;
        in_zone = (m <= DZ);
    endfunction

    // a stick pushed hard at power-up is not mistaken for its resting point
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            off_x_q <= '0;
            off_y_q <= '0;
        end else if (cal) begin
            off_x_q <= in_zone(raw[AXIS_W-1:0])        ? raw[AXIS_W-1:0]        : '0;
            off_y_q <= in_zone(raw[2*AXIS_W-1:AXIS_W]) ? raw[2*AXIS_W-1:AXIS_W] : '0;
        end
    end

    assign vx = sat_sub(raw[AXIS_W-1:0], off_x_q);
    assign vy = sat_sub(raw[2*AXIS_W-1:AXIS_W], off_y_q);
`else
    logic unused_cal;
    assign unused_cal = cal;
    assign vx = raw[AXIS_W-1:0];
    assign vy = raw[2*AXIS_W-1:AXIS_W];
`endif

    analog_dir_axis #(.AXIS_W(AXIS_W), .DEAD_ZONE(DEAD_ZONE), .HYST(HYST), .DEBOUNCE(DEBOUNCE))
        u_ax_x (.clk_sys, .reset_n, .eval, .v(vx), .pos(x_pos), .neg(x_neg), .act_nxt(x_nxt));
    analog_dir_axis #(.AXIS_W(AXIS_W), .DEAD_ZONE(DEAD_ZONE), .HYST(HYST), .DEBOUNCE(DEBOUNCE))
        u_ax_y (.clk_sys, .reset_n, .eval, .v(vy), .pos(y_pos), .neg(y_neg), .act_nxt(y_nxt));

    assign x_act = x_pos | x_neg;
    assign y_act = y_pos | y_neg;

    // primary follows whichever axis is alone off-centre; a joint departure goes to Y
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                    prim_y_q <= 1'b1;
        else if (eval) begin
            if (!x_nxt)                  prim_y_q <= 1'b1;
            else if (!y_nxt)             prim_y_q <= 1'b0;
            else if (!x_act && !y_act)   prim_y_q <= 1'b1;
        end
    end

    always_comb begin
        analog = {y_neg, y_pos, x_neg, x_pos};
        if (four_way && x_act && y_act)
            analog = prim_y_q ? {y_neg, y_pos, 2'b00} : {2'b00, x_neg, x_pos};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) dir <= '0;
        else          dir <= analog | dig;
    end
endmodule

module analog_dir_mapper #(
    parameter int NUM_CH    = 4,
    parameter int AXIS_W    = 8,
    parameter int DEAD_ZONE = 32,
    parameter int HYST      = 8,
    parameter int DEBOUNCE  = 2
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    analog_dir_mapper_if.slave bus
);
    logic eval, cal;
    logic [NUM_CH-1:0][3:0] dir;

`ifdef ANALOG_DIR_AUTOCAL_EN
    logic cal_done_q;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)           cal_done_q <= 1'b0;
        else if (bus.sample_en) cal_done_q <= 1'b1;
    end
    assign cal  = bus.sample_en & ~cal_done_q;
    assign eval = bus.sample_en &  cal_done_q;
`else
    assign cal  = 1'b0;
    assign eval = bus.sample_en;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        analog_dir_chan #(.AXIS_W(AXIS_W), .DEAD_ZONE(DEAD_ZONE), .HYST(HYST), .DEBOUNCE(DEBOUNCE))
            u_chan (
                .clk_sys, .reset_n, .eval, .cal,
                .raw      (bus.analog_in[c]),
                .dig      (bus.dig_in[c]),
                .four_way (bus.four_way[c]),
                .dir      (dir[c])
            );
        assign bus.active[c] = |dir[c];
    end

    assign bus.dir_out = dir;
endmodule

// File: tb/tb_analog_dir_mapper.sv
// Randomised + directed bench for analog_dir_mapper against a sample-history model.
module tb_analog_dir_mapper;
    localparam int NUM_CH = 4, AXIS_W = 8, DEBOUNCE = 2;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0, failures = 0;

    analog_dir_mapper_if #(.NUM_CH(NUM_CH), .AXIS_W(AXIS_W)) bus ();
    analog_dir_mapper #(.NUM_CH(NUM_CH), .AXIS_W(AXIS_W), .DEAD_ZONE(32), .HYST(8), .DEBOUNCE(DEBOUNCE))
        dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));

    always #5 clk_sys = ~clk_sys;

    // model: per axis committed direction (-1/0/+1), last DEBOUNCE+1 candidates, departure time
    int m_st   [NUM_CH][2];
    int m_hist [NUM_CH][2][DEBOUNCE+1];
    int m_leave[NUM_CH][2];
    int m_t;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < 2; a++) begin
                m_st[c][a] = 0;
                m_leave[c][a] = 0;
                for (int k = 0; k <= DEBOUNCE; k++) m_hist[c][a][k] = 99;
            end
        m_t = 0;
    endtask

    function automatic int cand_of(int st, int v);
        int mag = (v < 0) ? -v : v;
        int sgn = (v < 0) ? -1 : 1;
        if (st == 0) return (mag >= 32) ? sgn : 0;
        if (sgn != st && mag >= 32) return sgn;
        if (mag < 24) return 0;
        return st;
    endfunction

    task automatic model_sample();
        logic signed [7:0] b;
        int v, cd;
        bit same;
        m_t++;
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < 2; a++) begin
                b  = bus.analog_in[c][a*8 +: 8];
                v  = b;
                cd = cand_of(m_st[c][a], v);
                for (int k = DEBOUNCE; k > 0; k--) m_hist[c][a][k] = m_hist[c][a][k-1];
                m_hist[c][a][0] = cd;
                same = 1'b1;
                for (int k = 0; k <= DEBOUNCE; k++) if (m_hist[c][a][k] != cd) same = 1'b0;
                if (same && cd != m_st[c][a]) begin
                    if (m_st[c][a] == 0) m_leave[c][a] = m_t;
                    m_st[c][a] = cd;
                end
            end
    endtask

    function automatic logic [3:0] model_dir(int c);
        int x = m_st[c][0];
        int y = m_st[c][1];
        logic [3:0] d;
        d = {y < 0, y > 0, x < 0, x > 0};
        if (bus.four_way[c] && x != 0 && y != 0)
            d = (m_leave[c][1] <= m_leave[c][0]) ? {d[3:2], 2'b00} : {2'b00, d[1:0]};
        return d | bus.dig_in[c];
    endfunction

    task automatic sample();
        @(negedge clk_sys) bus.sample_en = 1'b1;
        @(negedge clk_sys) bus.sample_en = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic do_reset(input bit cal_zero);
        @(negedge clk_sys);
        reset_n = 1'b0;
        bus.sample_en = 1'b0;
        bus.analog_in = '0;
        bus.dig_in    = '0;
        bus.four_way  = '0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
`ifdef ANALOG_DIR_AUTOCAL_EN
        if (cal_zero) sample();
`else
        if (cal_zero) @(negedge clk_sys);
`endif
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        bus.sample_en = 1'b0;
        bus.analog_in = '0;
        bus.four_way  = '0;
        bus.dig_in    = '1;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (bus.dir_out !== '0) begin
            failures++; $display("FAIL reset_dir got=%h exp=0", bus.dir_out);
        end
        checks++;
        if (bus.active !== '0) begin
            failures++; $display("FAIL reset_active got=%b exp=0", bus.active);
        end
        do_reset(1);
        @(negedge clk_sys);
        checks++;
        if (bus.dir_out !== '0) begin
            failures++; $display("FAIL post_reset_dir got=%h exp=0", bus.dir_out);
        end
    endtask

    task automatic test_debounce();
        do_reset(1);
        bus.analog_in[0][7:0] = 8'd40;
        for (int s = 1; s <= 3; s++) begin
            sample();
            checks++;
            if (bus.dir_out[0] !== ((s == 3) ? 4'b0001 : 4'b0000)) begin
                failures++; $display("FAIL debounce_s%0d got=%b exp=%b", s, bus.dir_out[0],
                                     (s == 3) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_hysteresis();
        // carries on from the committed right stroke of test_debounce
        bus.analog_in[0][7:0] = 8'd30; repeat (3) sample();
        bus.analog_in[0][7:0] = 8'd25; repeat (3) sample();
        bus.analog_in[0][7:0] = 8'd24; repeat (3) sample();
        checks++;
        if (bus.dir_out[0] !== 4'b0001) begin
            failures++; $display("FAIL hyst_hold got=%b exp=0001", bus.dir_out[0]);
        end
        bus.analog_in[0][7:0] = 8'd23;
        for (int s = 1; s <= 3; s++) begin
            sample();
            checks++;
            if (bus.dir_out[0] !== ((s == 3) ? 4'b0000 : 4'b0001)) begin
                failures++; $display("FAIL hyst_exit_s%0d got=%b", s, bus.dir_out[0]);
            end
        end
    endtask

    task automatic test_wrap_reverse();
        do_reset(1);
        bus.analog_in[1] = {8'd0, 8'h80};
        repeat (3) sample();
        checks++;
        if (bus.dir_out[1] !== 4'b0010) begin
            failures++; $display("FAIL minneg_left got=%b exp=0010", bus.dir_out[1]);
        end
        bus.analog_in[1][7:0] = 8'd127;
        for (int s = 1; s <= 3; s++) begin
            sample();
            checks++;
            if (bus.dir_out[1] !== ((s == 3) ? 4'b0001 : 4'b0010)) begin
                failures++; $display("FAIL reverse_s%0d got=%b", s, bus.dir_out[1]);
            end
        end
    endtask

    task automatic test_four_way();
        do_reset(1);
        bus.four_way[2] = 1'b1;
        bus.analog_in[2] = {8'hCE, 8'd0};          // Y=-50
        repeat (3) sample();
        bus.analog_in[2][7:0] = 8'd50;
        repeat (3) sample();
        checks++;
        if (bus.dir_out[2] !== 4'b1000) begin
            failures++; $display("FAIL fw_y_first got=%b exp=1000", bus.dir_out[2]);
        end
        bus.four_way[2] = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (bus.dir_out[2] !== 4'b1001) begin
            failures++; $display("FAIL fw_off got=%b exp=1001", bus.dir_out[2]);
        end
        bus.four_way[2] = 1'b1;
        bus.analog_in[2][15:8] = 8'd0;
        repeat (3) sample();
        checks++;
        if (bus.dir_out[2] !== 4'b0001) begin
            failures++; $display("FAIL fw_handover got=%b exp=0001", bus.dir_out[2]);
        end
        bus.analog_in[2] = '0;
        repeat (3) sample();
        bus.analog_in[2] = {8'd50, 8'd50};
        repeat (3) sample();
        checks++;
        if (bus.dir_out[2] !== 4'b0100) begin
            failures++; $display("FAIL fw_tie got=%b exp=0100", bus.dir_out[2]);
        end
    endtask

    task automatic test_dig_and_async_reset();
        do_reset(1);
        @(negedge clk_sys) bus.dig_in[3] = 4'b0100;
        #1;
        checks++;
        if (bus.dir_out[3] !== 4'b0000) begin
            failures++; $display("FAIL dig_early got=%b exp=0000", bus.dir_out[3]);
        end
        @(negedge clk_sys);
        checks++;
        if (bus.dir_out[3] !== 4'b0100 || bus.active[3] !== 1'b1) begin
            failures++; $display("FAIL dig_pass got=%b/%b exp=0100/1", bus.dir_out[3], bus.active[3]);
        end
        bus.analog_in[0][7:0] = 8'd40;
        repeat (2) sample();
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.dir_out !== '0 || bus.active !== '0) begin
            failures++; $display("FAIL async_reset got=%h/%b exp=0/0", bus.dir_out, bus.active);
        end
        @(negedge clk_sys) reset_n = 1'b1;
`ifdef ANALOG_DIR_AUTOCAL_EN
        sample();
`endif
        repeat (2) sample();
        checks++;
        if (bus.dir_out[0] !== 4'b0000) begin
            failures++; $display("FAIL restart_early got=%b exp=0000", bus.dir_out[0]);
        end
        sample();
        checks++;
        if (bus.dir_out[0] !== 4'b0001) begin
            failures++; $display("FAIL restart_commit got=%b exp=0001", bus.dir_out[0]);
        end
    endtask

    task automatic test_autocal();
`ifdef ANALOG_DIR_AUTOCAL_EN
        do_reset(0);
        bus.analog_in[0][7:0] = 8'd20;
        sample();
`else
        do_reset(1);
        bus.analog_in[0][7:0] = 8'd20;
        repeat (3) sample();
`endif
        checks++;
        if (bus.dir_out[0] !== 4'b0000) begin
            failures++; $display("FAIL cal_20 got=%b exp=0000", bus.dir_out[0]);
        end
        bus.analog_in[0][7:0] = 8'd52;
        repeat (3) sample();
        checks++;
        if (bus.dir_out[0] !== 4'b0001) begin
            failures++; $display("FAIL cal_52 got=%b exp=0001", bus.dir_out[0]);
        end
        bus.analog_in[0][7:0] = 8'd10;
        repeat (3) sample();
        checks++;
        if (bus.dir_out[0] !== 4'b0000) begin
            failures++; $display("FAIL cal_10 got=%b exp=0000", bus.dir_out[0]);
        end
    endtask

    task automatic test_random();
        int tbl[12] = '{0, 23, 24, -24, 31, 32, -32, 40, -40, -128, 127, -23};
        logic [NUM_CH-1:0] exp_act;
        logic [3:0] exp_d;
        int v;
        do_reset(1);
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int a = 0; a < 2; a++)
                    if ($urandom_range(0, 2) == 0) begin
                        v = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 255)) - 128
                                                        : tbl[$urandom_range(0, 11)];
                        bus.analog_in[c][a*8 +: 8] = v[7:0];
                    end
            if ($urandom_range(0, 15) == 0) bus.four_way = NUM_CH'($urandom);
            bus.dig_in = ($urandom_range(0, 9) == 0) ? (4*NUM_CH)'($urandom) : '0;
            sample();
            model_sample();
            for (int c = 0; c < NUM_CH; c++) begin
                exp_d = model_dir(c);
                exp_act[c] = |exp_d;
                checks++;
                if (bus.dir_out[c] !== exp_d) begin
                    failures++;
                    $display("FAIL rand_dir n=%0d ch=%0d got=%b exp=%b", n, c, bus.dir_out[c], exp_d);
                end
            end
            checks++;
            if (bus.active !== exp_act) begin
                failures++; $display("FAIL rand_active n=%0d got=%b exp=%b", n, bus.active, exp_act);
            end
        end
    endtask

    initial begin
        bus.sample_en = 1'b0;
        bus.analog_in = '0;
        bus.dig_in    = '0;
        bus.four_way  = '0;
        test_reset();
        test_debounce();
        test_hysteresis();
        test_wrap_reverse();
        test_four_way();
        test_dig_and_async_reset();
        test_autocal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
